instruction_decoder: RTL and testbench

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

---
 rtl/instruction_decoder.sv | 109 ++++++++++
 tb/tb_instruction_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_decoder.sv
// Fetch/decode sequencer: registers PC and IR, decodes IR combinationally into datapath controls.
// Latency: one cycle from program word to IR; no backpressure, fetch advances every cycle.
module instruction_decoder (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic [7:0] pm_data,
    input  logic       r_eq_0,
    output logic [7:0] pm_addr,
    output logic [7:0] ir,
    output logic [3:0] ir_nibble,
    output logic [8:0] reg_en,
    output logic [3:0] source_sel,
    output logic       i_sel,
    output logic       x_sel,
    output logic       y_sel
);

    logic [7:0] pm_addr_q, pm_addr_d;
    logic [7:0] ir_q, ir_d;
    logic       valid_q, valid_d;

    logic [2:0] d_code;
    logic [2:0] s_code;
    logic       has_dest;
    logic       is_move;
    logic       jump_taken;
    logic [8:0] dest_en;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pm_addr_q <= 8'h00;
            ir_q      <= 8'h00;
            valid_q   <= 1'b0;
        end else begin
            pm_addr_q <= pm_addr_d;
            ir_q      <= ir_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        d_code     = 3'd0;
        s_code     = 3'd0;
        has_dest   = 1'b0;
        is_move    = 1'b0;
        jump_taken = 1'b0;
        reg_en     = 9'h000;
        source_sel = 4'd0;
        i_sel      = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;

        if (valid_q) begin
            if (!ir_q[7]) begin
                has_dest   = 1'b1;
                d_code     = ir_q[6:4];
                source_sel = 4'd8;
            end else if (!ir_q[6]) begin
                has_dest = 1'b1;
                is_move  = 1'b1;
                d_code   = ir_q[5:3];
                s_code   = ir_q[2:0];
                // r -> o_reg is not a useful move, so that encoding reads the input pins
                if (d_code == 3'd4 && s_code == 3'd4) begin
                    source_sel = 4'd9;
                end else begin
                    source_sel = {1'b0, s_code};
                end
            end else if (!ir_q[5]) begin
                reg_en[4] = 1'b1;
                x_sel     = ir_q[4];
                y_sel     = ir_q[3];
            end else if (!ir_q[4]) begin
                jump_taken = 1'b1;
            end else begin
                jump_taken = !r_eq_0;
            end
        end

        case (d_code)
            3'd0:    dest_en = 9'h001;
            3'd1:    dest_en = 9'h002;
            3'd2:    dest_en = 9'h004;
            3'd3:    dest_en = 9'h008;
            3'd4:    dest_en = 9'h100;
            3'd5:    dest_en = 9'h020;
            3'd6:    dest_en = 9'h040;
            default: dest_en = 9'h080;
        endcase

        if (has_dest) begin
            reg_en = dest_en;
            // Any dm access post-increments i, unless i itself is being loaded from the bus
            if (d_code == 3'd7 || (is_move && s_code == 3'd7)) begin
                reg_en[6] = 1'b1;
                i_sel     = (d_code != 3'd6);
            end
        end

        pm_addr_d = jump_taken ? {ir_q[3:0], 4'h0} : pm_addr_q + 8'd1;
        ir_d      = pm_data;
        valid_d   = 1'b1;
    end

    assign pm_addr   = pm_addr_q;
    assign ir        = ir_q;
    assign ir_nibble = ir_q[3:0];

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder: decode table plus sequencing/reset scenarios.
module tb_instruction_decoder;

    logic       clk;
    logic       sync_reset;
    logic [7:0] pm_data;
    logic       r_eq_0;
    logic [7:0] pm_addr;
    logic [7:0] ir;
    logic [3:0] ir_nibble;
    logic [8:0] reg_en;
    logic [3:0] source_sel;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;

    logic [7:0] pm [256];
    assign pm_data = pm[pm_addr];

    int checks = 0;
    int errors = 0;

    instruction_decoder dut (
        .clk       (clk),
        .sync_reset(sync_reset),
        .pm_data   (pm_data),
        .r_eq_0    (r_eq_0),
        .pm_addr   (pm_addr),
        .ir        (ir),
        .ir_nibble (ir_nibble),
        .reg_en    (reg_en),
        .source_sel(source_sel),
        .i_sel     (i_sel),
        .x_sel     (x_sel),
        .y_sel     (y_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] word;
        logic       req;
        logic [8:0] reg_en;
        logic [3:0] src;
        logic       isel;
        logic       xsel;
        logic       ysel;
    } vec_t;

    vec_t tbl [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_pm();
        for (int a = 0; a < 256; a++) pm[a] = 8'h00;
    endtask

    // Holds reset for two edges; releases with pm[0]=w and clocks it into ir.
    task automatic reset_and_load(input logic [7:0] w);
        sync_reset = 1'b1;
        step();
        step();
        pm[0] = w;
        sync_reset = 1'b0;
        step();
    endtask

    initial begin
        sync_reset = 1'b1;
        r_eq_0     = 1'b1;
        clear_pm();

        tbl[0]  = '{8'h05, 1'b1, 9'h001, 4'd8, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{8'h35, 1'b1, 9'h008, 4'd8, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{8'hA4, 1'b1, 9'h100, 4'd9, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{8'h8C, 1'b1, 9'h002, 4'd4, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{8'hDA, 1'b1, 9'h010, 4'd0, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{8'h70, 1'b1, 9'h0C0, 4'd8, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{8'hB7, 1'b1, 9'h040, 4'd7, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{8'hBF, 1'b1, 9'h0C0, 4'd7, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{8'h9B, 1'b1, 9'h008, 4'd3, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{8'h87, 1'b1, 9'h041, 4'd7, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{8'hC8, 1'b1, 9'h010, 4'd0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{8'hE3, 1'b1, 9'h000, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{8'hF3, 1'b0, 9'h000, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{8'h4A, 1'b1, 9'h100, 4'd8, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{8'h60, 1'b1, 9'h040, 4'd8, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{8'hAC, 1'b1, 9'h020, 4'd4, 1'b0, 1'b0, 1'b0};

        // Reset state: ir=0x00 would decode as a load, so outputs must be gated by valid
        pm[0] = 8'h70;
        step();
        step();
        chk("rst_pm_addr", pm_addr, 8'h00);
        chk("rst_ir", ir, 8'h00);
        chk("rst_reg_en", reg_en, 9'h000);
        chk("rst_source_sel", source_sel, 4'd0);
        chk("rst_sels", {i_sel, x_sel, y_sel}, 3'b000);

        for (int k = 0; k < 16; k++) begin
            r_eq_0 = tbl[k].req;
            reset_and_load(tbl[k].word);
            chk($sformatf("v%0d_ir", k), ir, tbl[k].word);
            chk($sformatf("v%0d_pm_addr", k), pm_addr, 8'h01);
            chk($sformatf("v%0d_reg_en", k), reg_en, tbl[k].reg_en);
            chk($sformatf("v%0d_source_sel", k), source_sel, tbl[k].src);
            chk($sformatf("v%0d_nibble", k), ir_nibble, tbl[k].word & 8'h0F);
            chk($sformatf("v%0d_sels", k), {i_sel, x_sel, y_sel},
                {tbl[k].isel, tbl[k].xsel, tbl[k].ysel});
        end

        // Jumps, delay slots, conditional jumps, jump in a delay slot
        clear_pm();
        pm[8'h01] = 8'h05;
        pm[8'h10] = 8'hE3;
        pm[8'h11] = 8'h1A;
        pm[8'h30] = 8'hF3;
        pm[8'h31] = 8'hF3;
        pm[8'h32] = 8'hE5;
        r_eq_0 = 1'b1;
        reset_and_load(8'hE1);
        chk("j_first_pm_addr", pm_addr, 8'h01);
        chk("j_first_reg_en", reg_en, 9'h000);
        step();
        chk("j_slot0_pm_addr", pm_addr, 8'h10);
        chk("j_slot0_reg_en", reg_en, 9'h001);
        step();
        chk("j_e3_ir", ir, 8'hE3);
        step();
        chk("j_e3_slot_ir", ir, 8'h1A);
        chk("j_e3_slot_reg_en", reg_en, 9'h002);
        chk("j_e3_target", pm_addr, 8'h30);
        step();
        chk("cj_ir", ir, 8'hF3);
        step();
        chk("cj_not_taken", pm_addr, 8'h32);
        r_eq_0 = 1'b0;
        step();
        chk("cj_taken", pm_addr, 8'h30);
        chk("cj_slot_ir", ir, 8'hE5);
        r_eq_0 = 1'b1;
        step();
        chk("slot_jump_target", pm_addr, 8'h50);
        step();
        chk("after_slot_jump_ir", ir, 8'h00);
        chk("after_slot_jump_pm_addr", pm_addr, 8'h51);

        // PC wrap from 0xFF to 0x00
        clear_pm();
        reset_and_load(8'hEF);
        step();
        chk("wrap_jump", pm_addr, 8'hF0);
        for (int n = 0; n < 15; n++) step();
        chk("wrap_ff", pm_addr, 8'hFF);
        step();
        chk("wrap_00", pm_addr, 8'h00);

        // Reset overrides a taken jump sitting in ir
        clear_pm();
        pm[8'h01] = 8'h22;
        reset_and_load(8'hE3);
        chk("ovr_ir_jump", ir, 8'hE3);
        sync_reset = 1'b1;
        step();
        chk("ovr_pm_addr", pm_addr, 8'h00);
        chk("ovr_ir", ir, 8'h00);
        chk("ovr_reg_en", reg_en, 9'h000);
        pm[0] = 8'h44;
        sync_reset = 1'b0;
        step();
        chk("ovr_release_ir", ir, 8'h44);
        chk("ovr_release_pm_addr", pm_addr, 8'h01);
        chk("ovr_release_reg_en", reg_en, 9'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
